// File: rtl/ireorder_ma_gen.sv
// ----------------------------------------------------------------------------
// ireorder_ma_gen
//
// Address generator for the inverse re-order stage of the radix-16 FFT
// datapath. A start pulse launches a walk over 16^DIGITS sample indices. Each
// enabled cycle issues the radix-16 digit-reversed form of the current index.
// The reversed index is split into a memory address and a bank number. The
// result then passes through a 2-stage pipeline that matches the data-path
// latency.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   start_i  in   frame start pulse, sampled only in IDLE
//   en_i     in   advance enable, one address per enabled RUN cycle
//   MA_o     out  memory address  = rev[IW-1:4]
//   BN_o     out  bank number     = rev[3:0]
//   valid_o  out  MA_o/BN_o carry a valid address this cycle
//   last_o   out  final address of the frame (index N-1), only with valid_o
//   busy_o   out  high in RUN and DRAIN
//   done_o   out  one-cycle pulse once the frame has fully drained
// ----------------------------------------------------------------------------
module ireorder_ma_gen #(
  parameter int DIGITS   = 3,
  parameter int MA_WIDTH = 4*DIGITS-4   // must equal 4*DIGITS-4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                en_i,
  output logic [MA_WIDTH-1:0] MA_o,
  output logic [3:0]          BN_o,
  output logic                valid_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int IW = 4*DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_cnt, w_cnt_nxt;
  logic [IW-1:0]       w_rev;
  logic                r_drain, w_drain_nxt;
  logic                w_issue, w_issue_last;

  logic [MA_WIDTH-1:0] r_s0_ma, r_s1_ma;
  logic [3:0]          r_s0_bn, r_s1_bn;
  logic                r_s0_valid, r_s1_valid;
  logic                r_s0_last, r_s1_last;

  // Digit reversal: the least-significant digit of cnt becomes the most
  // significant digit of rev, and so on down.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_rev[IW-1-4*i -: 4] = r_cnt[4*i +: 4];
    end
  end

  // Next-state and issue logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_drain_nxt  = r_drain;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (en_i) begin
          w_issue = 1'b1;
          if (&r_cnt) begin
            // Final index: flag it, wrap the counter and start draining.
            w_issue_last = 1'b1;
            w_cnt_nxt    = '0;
            w_drain_nxt  = 1'b0;
            w_state_nxt  = S_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Two drain cycles let the last address reach the output stage. That
        // arrival is the second drain cycle, which is also when done_o fires.
        w_drain_nxt = ~r_drain;
        if (r_drain) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_drain_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Output pipeline. It advances every cycle, and a cycle without an issue
  // enters as a bubble (valid=0). The address fields load unconditionally.
  // Consumers gate on valid_o.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are a handful of flops rather than a memory array. Resetting
    // them gives clean all-zero outputs after rst at negligible cost.
    if (rst) begin
      r_s0_ma    <= '0;
      r_s0_bn    <= '0;
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s1_ma    <= '0;
      r_s1_bn    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s0_ma    <= w_rev[IW-1:4];
      r_s0_bn    <= w_rev[3:0];
      r_s0_valid <= w_issue;
      r_s0_last  <= w_issue_last;
      r_s1_ma    <= r_s0_ma;
      r_s1_bn    <= r_s0_bn;
      r_s1_valid <= r_s0_valid;
      r_s1_last  <= r_s0_last;
    end
  end

  assign MA_o    = r_s1_ma;
  assign BN_o    = r_s1_bn;
  assign valid_o = r_s1_valid;
  assign last_o  = r_s1_last;
  assign busy_o  = (r_state != S_IDLE);
  // Decoded from registered state only; no input reaches done_o.
  assign done_o  = (r_state == S_DRAIN) && r_drain;

endmodule

// File: tb/tb_ireorder_ma_gen.sv
module tb_ireorder_ma_gen;

  localparam int DIGITS   = 3;
  localparam int MA_WIDTH = 4*DIGITS-4;
  localparam int N        = 16**DIGITS;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_i = 1'b0;
  logic                en_i = 1'b0;
  logic [MA_WIDTH-1:0] MA_o;
  logic [3:0]          BN_o;
  logic                valid_o, last_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;

  ireorder_ma_gen #(.DIGITS(DIGITS), .MA_WIDTH(MA_WIDTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .en_i(en_i),
    .MA_o(MA_o), .BN_o(BN_o), .valid_o(valid_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Frame progress: 0 = idle, 1 = running, 2 = draining.
  typedef struct {bit v; bit last; int idx;} rec_t;
  int   m_ph = 0, m_k = 0, m_dleft = 0;
  rec_t m_s0 = '{0, 0, 0};
  rec_t m_s1 = '{0, 0, 0};

  logic                e_valid, e_last, e_busy, e_done;
  logic [MA_WIDTH-1:0] e_ma;
  logic [3:0]          e_bn;

  // Digit reversal by arithmetic: peel digits off the bottom, push them on
  // the bottom of the result.
  function automatic int rev_of(input int idx);
    int r = 0;
    int x = idx;
    for (int i = 0; i < DIGITS; i++) begin
      r = r*16 + (x % 16);
      x = x / 16;
    end
    return r;
  endfunction

  task automatic model_edge(input logic st, input logic en);
    rec_t iss;
    if (rst) begin
      m_ph = 0; m_k = 0; m_dleft = 0;
      m_s0 = '{0, 0, 0}; m_s1 = '{0, 0, 0};
    end else begin
      iss = '{0, 0, m_k};
      case (m_ph)
        0: if (st) begin m_ph = 1; m_k = 0; end
        1: if (en) begin
             iss.v    = 1;
             iss.last = (m_k == N-1);
             if (m_k == N-1) begin m_ph = 2; m_dleft = 2; m_k = 0; end
             else m_k++;
           end
        default: begin m_dleft--; if (m_dleft == 0) m_ph = 0; end
      endcase
      m_s1 = m_s0;
      m_s0 = iss;
    end
    e_valid = m_s1.v;
    e_last  = m_s1.last;
    e_busy  = (m_ph != 0);
    e_done  = (m_ph == 2) && (m_dleft == 1);
    e_ma    = MA_WIDTH'(rev_of(m_s1.idx) >> 4);
    e_bn    = 4'(rev_of(m_s1.idx) & 15);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic step(input logic st, input logic en);
    start_i = st;
    en_i    = en;
    @(posedge clk);
    model_edge(st, en);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(0, 0);
    checks++; if (MA_o !== '0)     begin failures++; $display("FAIL reset_MA got=%h exp=0", MA_o); end
    checks++; if (BN_o !== '0)     begin failures++; $display("FAIL reset_BN got=%h exp=0", BN_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (last_o !== 1'b0)  begin failures++; $display("FAIL reset_last got=%b exp=0", last_o); end
    checks++; if (busy_o !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    rst = 1'b0;
    step(0, 0);
  endtask

  task automatic test_reset_mid();
    int  steps = 0;
    bit  first_seen = 0;
    step(1, 0);
    while (m_k != 'h050 && steps < 200) begin step(0, 1); steps++; end
    checks++; if (m_k != 'h050) begin failures++; $display("FAIL reset_mid_reach got=%0d exp=80", m_k); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({MA_o, BN_o, valid_o, last_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got MA=%h BN=%h v=%b l=%b b=%b d=%b exp all 0",
               MA_o, BN_o, valid_o, last_o, busy_o, done_o);
    end
    step(0, 0);
    rst = 1'b0;
    step(0, 0);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL reset_mid_idle got b=%b d=%b exp 0 0", busy_o, done_o); end
    // A fresh frame must restart at index 0.
    step(1, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1);
      checks++;
      if ({valid_o, last_o, busy_o, done_o} !== {e_valid, e_last, e_busy, e_done} ||
          (e_valid && (MA_o !== e_ma || BN_o !== e_bn))) begin
        failures++;
        $display("FAIL reset_mid_cycle got v=%b l=%b b=%b d=%b MA=%h BN=%h exp v=%b l=%b b=%b d=%b MA=%h BN=%h",
                 valid_o, last_o, busy_o, done_o, MA_o, BN_o, e_valid, e_last, e_busy, e_done, e_ma, e_bn);
      end
      if (valid_o && !first_seen) begin
        first_seen = 1;
        checks++; if (MA_o !== 8'h00 || BN_o !== 4'h0) begin failures++; $display("FAIL reset_mid_first got MA=%h BN=%h exp 00 0", MA_o, BN_o); end
      end
    end
    checks++; if (!first_seen) begin failures++; $display("FAIL reset_mid_nofirst got none exp valid"); end
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    step(0, 0);
  endtask

  task automatic test_basic_frame();
    int         nvalid = 0, ndone = 0, steps = 0, hits = 0;
    int         tab_idx [4];
    logic [7:0] tab_ma  [4];
    logic [3:0] tab_bn  [4];
    tab_idx = '{'h000, 'h001, 'h123, 'hFFF};
    tab_ma  = '{8'h00, 8'h10, 8'h32, 8'hFF};
    tab_bn  = '{4'h0, 4'h0, 4'h1, 4'hF};
    step(1, 0);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", busy_o); end
    while (e_busy && steps < N + 20) begin
      step(0, 1);
      steps++;
      checks++;
      if ({valid_o, last_o, busy_o, done_o} !== {e_valid, e_last, e_busy, e_done} ||
          (e_valid && (MA_o !== e_ma || BN_o !== e_bn))) begin
        failures++;
        $display("FAIL basic_cycle got v=%b l=%b b=%b d=%b MA=%h BN=%h exp v=%b l=%b b=%b d=%b MA=%h BN=%h",
                 valid_o, last_o, busy_o, done_o, MA_o, BN_o, e_valid, e_last, e_busy, e_done, e_ma, e_bn);
      end
      if (valid_o) nvalid++;
      if (done_o) begin
        ndone++;
        checks++; if (last_o !== 1'b1 || valid_o !== 1'b1) begin failures++; $display("FAIL basic_done_align got l=%b v=%b exp 1 1", last_o, valid_o); end
      end
      for (int j = 0; j < 4; j++) begin
        if (e_valid && m_s1.idx == tab_idx[j]) begin
          hits++;
          checks++;
          if (MA_o !== tab_ma[j] || BN_o !== tab_bn[j] || last_o !== (j == 3)) begin
            failures++;
            $display("FAIL basic_idx_%0h got MA=%h BN=%h l=%b exp MA=%h BN=%h l=%b",
                     tab_idx[j], MA_o, BN_o, last_o, tab_ma[j], tab_bn[j], (j == 3));
          end
        end
      end
    end
    checks++; if (e_busy) begin failures++; $display("FAIL basic_timeout got steps=%0d exp frame end", steps); end
    checks++; if (nvalid !== N) begin failures++; $display("FAIL basic_nvalid got=%0d exp=%0d", nvalid, N); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL basic_ndone got=%0d exp=1", ndone); end
    checks++; if (hits !== 4) begin failures++; $display("FAIL basic_hits got=%0d exp=4", hits); end
  endtask

  task automatic test_stall();
    int   steps = 0, seq = 0;
    logic en, cur_iss, iss_prev = 1'b0;
    step(1, 0);
    while (e_busy && steps < 4*N) begin
      en      = 1'($urandom_range(0, 1));
      cur_iss = (m_ph == 1) && en;
      step(0, en);
      steps++;
      checks++;
      if ({valid_o, last_o, busy_o, done_o} !== {e_valid, e_last, e_busy, e_done} ||
          (e_valid && (MA_o !== e_ma || BN_o !== e_bn))) begin
        failures++;
        $display("FAIL stall_cycle got v=%b l=%b b=%b d=%b MA=%h BN=%h exp v=%b l=%b b=%b d=%b MA=%h BN=%h",
                 valid_o, last_o, busy_o, done_o, MA_o, BN_o, e_valid, e_last, e_busy, e_done, e_ma, e_bn);
      end
      // valid_o is the accepted enable delayed by two cycles.
      checks++; if (valid_o !== iss_prev) begin failures++; $display("FAIL stall_en_delay got=%b exp=%b", valid_o, iss_prev); end
      iss_prev = cur_iss;
      // Consecutive valid outputs walk the indices in order with no gaps.
      if (valid_o) begin
        checks++;
        if ({MA_o, BN_o} !== 12'(rev_of(seq))) begin
          failures++;
          $display("FAIL stall_seq got=%h exp=%h at seq=%0d", {MA_o, BN_o}, 12'(rev_of(seq)), seq);
        end
        seq++;
      end
    end
    checks++; if (e_busy) begin failures++; $display("FAIL stall_timeout got steps=%0d exp frame end", steps); end
    checks++; if (seq !== N) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", seq, N); end
  endtask

  task automatic test_start_ignored();
    int   nvalid = 0, ndone = 0, steps = 0;
    logic st;
    step(1, 0);
    while (e_busy && steps < N + 20) begin
      st = (m_ph == 1 && m_k == 'h200) || (m_ph == 2);
      step(st, 1);
      steps++;
      checks++;
      if ({valid_o, last_o, busy_o, done_o} !== {e_valid, e_last, e_busy, e_done} ||
          (e_valid && (MA_o !== e_ma || BN_o !== e_bn))) begin
        failures++;
        $display("FAIL ignore_cycle got v=%b l=%b b=%b d=%b MA=%h BN=%h exp v=%b l=%b b=%b d=%b MA=%h BN=%h",
                 valid_o, last_o, busy_o, done_o, MA_o, BN_o, e_valid, e_last, e_busy, e_done, e_ma, e_bn);
      end
      if (valid_o) nvalid++;
      if (done_o) ndone++;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1);
      checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got b=%b v=%b exp 0 0", busy_o, valid_o); end
    end
    checks++; if (nvalid !== N) begin failures++; $display("FAIL ignore_nvalid got=%0d exp=%0d", nvalid, N); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_back_to_back();
    int   nvalid = 0, ndone = 0, steps = 0, done_step = -1, first2 = -1;
    bit   restarted = 0;
    logic st;
    step(1, 0);
    while (steps < 3*N && !(restarted && !e_busy)) begin
      st = (done_step >= 0) && !restarted && (m_ph == 0);
      if (st) restarted = 1;
      step(st, 1);
      steps++;
      checks++;
      if ({valid_o, last_o, busy_o, done_o} !== {e_valid, e_last, e_busy, e_done} ||
          (e_valid && (MA_o !== e_ma || BN_o !== e_bn))) begin
        failures++;
        $display("FAIL b2b_cycle got v=%b l=%b b=%b d=%b MA=%h BN=%h exp v=%b l=%b b=%b d=%b MA=%h BN=%h",
                 valid_o, last_o, busy_o, done_o, MA_o, BN_o, e_valid, e_last, e_busy, e_done, e_ma, e_bn);
      end
      if (valid_o) nvalid++;
      if (done_o) begin ndone++; if (done_step < 0) done_step = steps; end
      if (valid_o && done_step >= 0 && steps > done_step && first2 < 0) begin
        first2 = steps;
        checks++; if (MA_o !== 8'h00 || BN_o !== 4'h0) begin failures++; $display("FAIL b2b_first got MA=%h BN=%h exp 00 0", MA_o, BN_o); end
      end
    end
    // done cycle, first IDLE cycle (start), first RUN cycle (issue), two pipe stages.
    checks++; if (first2 - done_step !== 4) begin failures++; $display("FAIL b2b_gap got=%0d exp=4", first2 - done_step); end
    checks++; if (nvalid !== 2*N) begin failures++; $display("FAIL b2b_nvalid got=%0d exp=%0d", nvalid, 2*N); end
    checks++; if (ndone !== 2) begin failures++; $display("FAIL b2b_ndone got=%0d exp=2", ndone); end
  endtask

  task automatic test_alignment();
    int steps = 0;
    step(1, 0);
    for (int i = 0; i < 'h0F0; i++) step(0, 1);
    for (int i = 0; i < 4; i++) step(0, 0);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL align_quiet got=%b exp=0", valid_o); end
    step(0, 1);   // the only enabled cycle, issuing index 0x0F0
    for (int j = 0; j < 6; j++) begin
      step(0, 0);
      checks++;
      if (valid_o !== (j == 0)) begin failures++; $display("FAIL align_valid j=%0d got=%b exp=%b", j, valid_o, (j == 0)); end
      if (j == 0) begin
        checks++; if (MA_o !== 8'h0F || BN_o !== 4'h0) begin failures++; $display("FAIL align_addr got MA=%h BN=%h exp 0f 0", MA_o, BN_o); end
      end
    end
    while (e_busy && steps < N + 20) begin step(0, 1); steps++; end
    checks++; if (e_busy || busy_o !== 1'b0) begin failures++; $display("FAIL align_finish got b=%b exp 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic_frame();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_alignment();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
